// File: rtl/csr_interrupt_arbiter_pkg.sv
// Shared types for the CSR interrupt arbiter: machine interrupt cause codes and FSM states.
package csr_interrupt_arbiter_pkg;

  typedef logic [3:0] cause_code_t;

  localparam cause_code_t CAUSE_MEI = 4'd11;
  localparam cause_code_t CAUSE_MSI = 4'd3;
  localparam cause_code_t CAUSE_MTI = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_FIRE,
    ST_HOLDOFF
  } arb_state_t;

endpackage

// File: rtl/csr_interrupt_arbiter_priority_encoder.sv
// Interrupt priority encoder: gates machine interrupt requests with their enables and
// picks the winner in the fixed order MEI > MSI > MTI.
module csr_interrupt_arbiter_priority_encoder
  import csr_interrupt_arbiter_pkg::*;
(
  input  logic       global_enable,
  input  logic       meie,
  input  logic       msie,
  input  logic       mtie,
  input  logic       req_external,
  input  logic       req_software,
  input  logic       req_timer,
  output logic       valid,
  output logic [3:0] code,
  output logic       is_external
);

  logic hit_external;
  logic hit_software;
  logic hit_timer;

  assign hit_external = global_enable & req_external & meie;
  assign hit_software = global_enable & req_software & msie;
  assign hit_timer    = global_enable & req_timer    & mtie;

  assign valid       = hit_external | hit_software | hit_timer;
  assign is_external = hit_external;

  // NOTE: code gets a default before the if-chain so no path leaves it unassigned (no latch).
  always_comb begin
    code = '0;
    if (hit_external)      code = CAUSE_MEI;
    else if (hit_software) code = CAUSE_MSI;
    else if (hit_timer)    code = CAUSE_MTI;
  end

endmodule

// File: rtl/csr_interrupt_arbiter.sv
// CSR interrupt arbiter: waits for a safe commit point, issues a one-cycle triggerInterrupt
// with cause and return PC, then holds off re-arbitration while the CSR trap update lands.
module csr_interrupt_arbiter
  import csr_interrupt_arbiter_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 4,
  parameter int EXT_CODE_WIDTH = 5,
  parameter int PC_WIDTH       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mstatusMIE,
  input  logic                      mieMEIE,
  input  logic                      mieMSIE,
  input  logic                      mieMTIE,
  input  logic                      reqExternal,
  input  logic [EXT_CODE_WIDTH-1:0] externalCode,
  input  logic                      reqSoftware,
  input  logic                      reqTimer,
  input  logic                      safeToInterrupt,
  input  logic                      triggerExcpt,
  input  logic [PC_WIDTH-1:0]       retirePC,
  output logic                      triggerInterrupt,
  output logic [3:0]                interruptCode,
  output logic [PC_WIDTH-1:0]       interruptRetAddr,
  output logic [EXT_CODE_WIDTH-1:0] externalCodeLatched,
  output logic                      busy
);

  localparam int CNT_W = $clog2(HOLDOFF_CYCLES) + 1;

  arb_state_t       state;
  arb_state_t       next_state;
  logic [CNT_W-1:0] holdoff_cnt;
  logic             eligible;
  logic [3:0]       winner_code;
  logic             winner_external;
  logic             load_outputs;

  csr_interrupt_arbiter_priority_encoder u_encoder (
    .global_enable (mstatusMIE),
    .meie          (mieMEIE),
    .msie          (mieMSIE),
    .mtie          (mieMTIE),
    .req_external  (reqExternal),
    .req_software  (reqSoftware),
    .req_timer     (reqTimer),
    .valid         (eligible),
    .code          (winner_code),
    .is_external   (winner_external)
  );

  always_comb begin
    next_state   = state;
    load_outputs = 1'b0;
    unique case (state)
      ST_IDLE:    if (eligible) next_state = ST_PENDING;
      ST_PENDING: begin
        // An exception in the same cycle wins; the interrupt stays pending and retries.
        if (!eligible) begin
          next_state = ST_IDLE;
        end else if (safeToInterrupt && !triggerExcpt) begin
          next_state   = ST_FIRE;
          load_outputs = 1'b1;
        end
      end
      ST_FIRE:    next_state = ST_HOLDOFF;
      ST_HOLDOFF: if (holdoff_cnt == '0) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= ST_IDLE;
      holdoff_cnt         <= '0;
      interruptCode       <= '0;
      interruptRetAddr    <= '0;
      externalCodeLatched <= '0;
    end else begin
      state <= next_state;
      if (state == ST_FIRE) begin
        holdoff_cnt <= CNT_W'(HOLDOFF_CYCLES - 1);
      end else if (state == ST_HOLDOFF && holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - CNT_W'(1);
      end
      if (load_outputs) begin
        interruptCode       <= winner_code;
        interruptRetAddr    <= retirePC;
        externalCodeLatched <= winner_external ? externalCode : '0;
      end
    end
  end

  assign triggerInterrupt = (state == ST_FIRE);
  assign busy             = (state != ST_IDLE);

endmodule
